// File: rtl/snn_pe_pkg.sv
// Shared definitions for the spiking convolution PE: FSM state encoding,
// counter width and the saturating-add helper used by snn_sat_add.
package snn_pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        CHAIN = 2'd2,
        OUT   = 2'd3
    } pe_state_t;

    // Wide enough to count up to the largest legal window of 16 products.
    localparam int CNT_W     = 4;
    localparam int SAT_MAX_W = 64;

    // Adds two sign-extended operands and clamps the sum to a signed w-bit
    // range. Returns {clamped, value}; only value[w-1:0] is meaningful.
    function automatic logic [SAT_MAX_W:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W:0] sum;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        sum = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
        hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo  = -hi - 65'sd1;
        if (sum > hi) begin
            return {1'b1, hi[SAT_MAX_W-1:0]};
        end else if (sum < lo) begin
            return {1'b1, lo[SAT_MAX_W-1:0]};
        end
        return {1'b0, sum[SAT_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/snn_sat_add.sv
// Saturating adder: IN_W-bit signed operands, result clamped to OUT_W bits
// (OUT_W < 64) with a flag reporting whether the clamp was applied.
module snn_sat_add
    import snn_pe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [OUT_W-1:0] sum,
    output logic                    sat
);

    logic [SAT_MAX_W:0]       res;
    logic [SAT_MAX_W-1:OUT_W] unused_hi;

    assign res       = sat_add(SAT_MAX_W'(a), SAT_MAX_W'(b), OUT_W);
    assign sum       = res[OUT_W-1:0];
    assign sat       = res[SAT_MAX_W];
    // Above OUT_W the clamped value is pure sign extension.
    assign unused_hi = res[SAT_MAX_W-1:OUT_W];

endmodule

// File: rtl/snn_conv_pe.sv
// Spiking convolution PE: accumulates FILTER_SIZE weight*spike products per
// window, optionally adds an upstream psum, then presents a saturated result.
module snn_conv_pe
    import snn_pe_pkg::*;
#(
    parameter int FILTER_DATA_WIDTH = 12,
    parameter int SPIKE_DATA_WIDTH  = 1,
    parameter int PSUM_WIDTH        = 16,
    parameter int FILTER_SIZE       = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [FILTER_DATA_WIDTH-1:0] in_filter,
    input  logic        [SPIKE_DATA_WIDTH-1:0]  in_spike,
    input  logic                                cfg_chain,
    input  logic                                psum_in_valid,
    output logic                                psum_in_ready,
    input  logic signed [PSUM_WIDTH-1:0]        psum_in_data,
    output logic                                psum_out_valid,
    input  logic                                psum_out_ready,
    output logic signed [PSUM_WIDTH-1:0]        psum_out_data,
    output logic                                psum_out_sat,
    output logic                                busy
);

    // One extra product bit keeps the spike unsigned in a signed multiply.
    localparam int PROD_W = FILTER_DATA_WIDTH + SPIKE_DATA_WIDTH + 1;
    localparam int ADD_W  = (PSUM_WIDTH > PROD_W) ? PSUM_WIDTH : PROD_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_SIZE - 1);

    pe_state_t                     state_reg, state_next;
    logic signed [PSUM_WIDTH-1:0]  acc_reg, acc_next;
    logic        [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                          sat_reg, sat_next;
    logic                          chain_reg, chain_next;

    logic signed [PROD_W-1:0]      product;
    logic signed [ADD_W-1:0]       add_a, add_b;
    logic signed [PSUM_WIDTH-1:0]  add_sum;
    logic                          add_sat;
    logic                          eff_chain;

    assign product = $signed(in_filter) * $signed({1'b0, in_spike});
    assign add_a   = ADD_W'(acc_reg);
    assign add_b   = (state_reg == CHAIN) ? ADD_W'(psum_in_data) : ADD_W'(product);

    snn_sat_add #(
        .IN_W  (ADD_W),
        .OUT_W (PSUM_WIDTH)
    ) u_sat_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .sat (add_sat)
    );

    // The first accept of a window sees cfg_chain live; later ones use the latch.
    assign eff_chain = (state_reg == IDLE) ? cfg_chain : chain_reg;

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        sat_next       = sat_reg;
        chain_next     = chain_reg;
        in_ready       = 1'b0;
        psum_in_ready  = 1'b0;
        psum_out_valid = 1'b0;
        case (state_reg)
            IDLE, ACC: begin
                in_ready = rst_n;
                if (in_valid) begin
                    acc_next   = add_sum;
                    sat_next   = sat_reg | add_sat;
                    chain_next = eff_chain;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = eff_chain ? CHAIN : OUT;
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = ACC;
                    end
                end
            end
            CHAIN: begin
                psum_in_ready = 1'b1;
                if (psum_in_valid) begin
                    acc_next   = add_sum;
                    sat_next   = sat_reg | add_sat;
                    state_next = OUT;
                end
            end
            OUT: begin
                psum_out_valid = 1'b1;
                if (psum_out_ready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                    chain_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
            chain_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sat_reg   <= sat_next;
            chain_reg <= chain_next;
        end
    end

    assign psum_out_data = acc_reg;
    assign psum_out_sat  = sat_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: doc/snn_conv_pe.md
SNN_CONV_PE -- requirements
Module: snn_conv_pe

Interface
REQ-001 Parameter FILTER_DATA_WIDTH, default 12: signed filter weight width.
REQ-002 Parameter SPIKE_DATA_WIDTH, default 1: unsigned spike/count width.
REQ-003 Parameter PSUM_WIDTH, default 16: signed partial-sum width; SHALL be >= FILTER_DATA_WIDTH.
REQ-004 Parameter FILTER_SIZE, default 3: products per window; legal range 1..16.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  PE accepts the operand pair.
- in_filter  in  FILTER_DATA_WIDTH  signed weight.
- in_spike  in  SPIKE_DATA_WIDTH  unsigned spike value.
- cfg_chain  in  1  1 = add upstream psum before output.
- psum_in_valid  in  1  upstream psum valid.
- psum_in_ready  out  1  PE accepts upstream psum.
- psum_in_data  in  PSUM_WIDTH  signed upstream psum.
- psum_out_valid  out  1  result valid.
- psum_out_ready  in  1  downstream accepts result.
- psum_out_data  out  PSUM_WIDTH  signed result.
- psum_out_sat  out  1  saturation occurred in this window.
- busy  out  1  window in progress (state not IDLE).

Function
REQ-006 Handshakes SHALL be valid/ready: transfer on a rising edge with valid and ready both high; valid SHALL NOT depend combinationally on ready.
REQ-007 FSM states: IDLE, ACC, CHAIN, OUT.
REQ-008 IDLE/ACC: in_ready=1; every other ready/valid output is 0.
REQ-009 Each accepted pair SHALL add the product in_filter*in_spike (signed x unsigned, FILTER_DATA_WIDTH+SPIKE_DATA_WIDTH bits) to the accumulator in the same edge.
REQ-010 Each addition SHALL saturate to the signed PSUM_WIDTH range; any clamp SHALL set a sticky sat bit for the window.
REQ-011 First accept in IDLE -> ACC; cfg_chain SHALL be latched on that edge and held for the window.
REQ-012 Window counter counts accepts 0..FILTER_SIZE-1; accept at count FILTER_SIZE-1 -> CHAIN if latched chain=1, else OUT; FILTER_SIZE=1 goes from IDLE directly.
REQ-013 CHAIN: psum_in_ready=1, in_ready=0; accepted psum_in_data SHALL be added with saturation (REQ-010) -> OUT.
REQ-014 OUT: psum_out_valid=1, data and sat registered and stable until handshake; in_ready=0, psum_in_ready=0.
REQ-015 OUT handshake: clear accumulator, counter and sat -> IDLE.
REQ-016 Latency: psum_out_valid SHALL rise the cycle after the last operand (chain=0) or the cycle after psum_in is accepted (chain=1).
REQ-017 Throughput: one operand per cycle when in_valid is held; gaps in in_valid SHALL stall the counter without loss.
REQ-018 psum_in_valid asserted outside CHAIN SHALL be ignored (not consumed).

Reset
REQ-019 rst_n low SHALL immediately force IDLE, accumulator=0, counter=0, sat=0, latched chain=0, all ready/valid outputs 0, psum_out_data=0, busy=0.
REQ-020 Reset mid-window SHALL discard the partial sum; the next window starts fresh after release.

Structure
REQ-021 State enum and the saturating-add function SHALL live in shared package snn_pe_pkg.
REQ-022 Saturating adder SHALL be one sub-module, snn_sat_add, instantiated once and shared by the ACC and CHAIN paths.

Verification (defaults unless stated)
REQ-023 filters 5,-3,7, spikes 1,0,1, chain=0, back-to-back -> psum_out_data=12, sat=0, valid one cycle after third accept.
REQ-024 same operands, chain=1, psum_in=100 presented 3 cycles late -> in_ready=0 while waiting, psum_out_data=112.
REQ-025 PSUM_WIDTH=12, filters 2047,2047,2047, spikes 1 -> psum_out_data=2047, psum_out_sat=1; next window of 1,1,1 -> 3, sat=0.
REQ-026 psum_out_ready low 5 cycles in OUT -> data/valid stable, in_ready=0, no operand consumed; release -> IDLE next edge.
REQ-027 rst_n pulsed after 2 accepts -> all outputs 0 at once; next 1,1,1 with spikes 1 -> 3.
REQ-028 in_valid toggled 1,0,1,0,1 with filters 4,4,4 and spikes 1 -> 12; psum_in_valid high throughout with chain=0 -> psum_in never consumed.
